// File: rtl/pending_write_cam.sv
// Circular FIFO of in-flight store addresses with a combinational associative
// lookup port, so loads can detect read-after-write hazards against pending stores.
module pending_write_cam #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  enq_valid,
  input  logic [ADDR_WIDTH-1:0] enq_addr,
  output logic                  enq_ready,
  input  logic                  deq_ready,
  output logic                  deq_valid,
  output logic [ADDR_WIDTH-1:0] deq_addr,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  lookup_hit,
  output logic [DEPTH-1:0]      lookup_hit_vec,
  output logic [PTR_WIDTH:0]    count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);

  logic [PTR_WIDTH-1:0]  head_q, head_d;
  logic [PTR_WIDTH-1:0]  tail_q, tail_d;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

  logic enq_fire;
  logic deq_fire;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid depend only on registered state, never on the peer.
  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign enq_ready = !full;
  assign deq_valid = !empty;
  assign count     = count_q;
  assign deq_addr  = addr_q[head_q];

  assign enq_fire = enq_valid && enq_ready;
  assign deq_fire = deq_ready && deq_valid;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end else begin
      // Enq and deq never touch the same slot: enq needs !full, deq needs !empty.
      if (enq_fire) begin
        valid_d[tail_q] = 1'b1;
        tail_d          = tail_q + 1'b1;
      end
      if (deq_fire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end
      if (enq_fire && !deq_fire) begin
        count_d = count_q + 1'b1;
      end else if (deq_fire && !enq_fire) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Flush leaves stored addresses alone; cleared valid bits make them don't-care.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
      end
    end else if (!flush && enq_fire) begin
      addr_q[tail_q] <= enq_addr;
    end
  end

  always_comb begin
    lookup_hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lookup_hit_vec[i] = valid_q[i] && (addr_q[i] == lookup_addr);
    end
  end

  assign lookup_hit = |lookup_hit_vec;

endmodule

// File: tb/tb_pending_write_cam.sv
// Bench for pending_write_cam: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pending_write_cam;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        enq_valid;
  logic [31:0] enq_addr;
  logic        enq_ready;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_addr;
  logic [31:0] lookup_addr;
  logic        lookup_hit;
  logic [7:0]  lookup_hit_vec;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  pending_write_cam #(.ADDR_WIDTH(32), .DEPTH(8), .PTR_WIDTH(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .enq_valid      (enq_valid),
    .enq_addr       (enq_addr),
    .enq_ready      (enq_ready),
    .deq_ready      (deq_ready),
    .deq_valid      (deq_valid),
    .deq_addr       (deq_addr),
    .lookup_addr    (lookup_addr),
    .lookup_hit     (lookup_hit),
    .lookup_hit_vec (lookup_hit_vec),
    .count          (count),
    .full           (full),
    .empty          (empty)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: oldest-first queue plus the physical slot of the oldest entry
  logic [31:0] exp_q[$];
  int          m_head;
  bit          m_e, m_d;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_head = 0;
    end else if (flush) begin
      exp_q.delete();
      m_head = 0;
    end else begin
      m_e = enq_valid && (exp_q.size() < 8);
      m_d = deq_ready && (exp_q.size() > 0);
      if (m_d) begin
        void'(exp_q.pop_front());
        m_head = (m_head + 1) % 8;
      end
      if (m_e) exp_q.push_back(enq_addr);
    end
  end

  // Scoreboard compare every cycle, away from the active edge
  logic [7:0] m_vec;
  always @(negedge clk) begin
    if (chk_en) begin
      m_vec = '0;
      for (int k = 0; k < exp_q.size(); k++) begin
        if (exp_q[k] == lookup_addr) m_vec[(m_head + k) % 8] = 1'b1;
      end
      check("count",      64'(count),          64'(exp_q.size()));
      check("full",       64'(full),           64'(exp_q.size() == 8));
      check("empty",      64'(empty),          64'(exp_q.size() == 0));
      check("enq_ready",  64'(enq_ready),      64'(exp_q.size() != 8));
      check("deq_valid",  64'(deq_valid),      64'(exp_q.size() != 0));
      check("hit_vec",    64'(lookup_hit_vec), 64'(m_vec));
      check("lookup_hit", 64'(lookup_hit),     64'(m_vec != 0));
      if (exp_q.size() > 0) check("deq_addr", 64'(deq_addr), 64'(exp_q[0]));
    end
  end

  // Driver tasks
  task automatic step(input logic ev, input logic [31:0] ea, input logic dr, input logic fl);
    enq_valid = ev;
    enq_addr  = ea;
    deq_ready = dr;
    flush     = fl;
    @(posedge clk);
    #1;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic enq(input logic [31:0] a);
    step(1'b1, a, 1'b0, 1'b0);
  endtask

  task automatic probe(input logic [31:0] a);
    lookup_addr = a;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_addr = '0;
    deq_ready = 1'b0; lookup_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_deq_addr", 64'(deq_addr), 64'h0);
    check("rst_empty",    64'(empty),    64'h1);
    reset = 1'b0;

    // 1: three enqueues
    enq(32'h1000); enq(32'h2000); enq(32'h3000);
    probe(32'h2000);
    check("t1_count", 64'(count),          64'd3);
    check("t1_head",  64'(deq_addr),       64'h1000);
    check("t1_hit",   64'(lookup_hit),     64'h1);
    check("t1_vec",   64'(lookup_hit_vec), 64'b0000_0010);

    // 2: fill, then enqueue while full is ignored
    do_reset();
    for (int i = 1; i <= 8; i++) enq(32'(i * 16));
    enq(32'h90);
    probe(32'h90);
    check("t2_full",  64'(full),       64'h1);
    check("t2_ready", 64'(enq_ready),  64'h0);
    check("t2_count", 64'(count),      64'd8);
    check("t2_hit",   64'(lookup_hit), 64'h0);

    // 3: enq+deq while full: only deq fires, then enq wraps to slot 0
    step(1'b1, 32'h90, 1'b1, 1'b0);
    check("t3_count", 64'(count),    64'd7);
    check("t3_head",  64'(deq_addr), 64'h20);
    enq(32'h90);
    probe(32'h90);
    check("t3_vec",   64'(lookup_hit_vec), 64'b0000_0001);
    check("t3_count2", 64'(count), 64'd8);

    // 4: drain, then enq+deq on empty: no bypass
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("t4_empty", 64'(empty), 64'h1);
    step(1'b1, 32'h55, 1'b1, 1'b0);
    probe(32'h55);
    check("t4_count", 64'(count),          64'd1);
    check("t4_valid", 64'(deq_valid),      64'h1);
    check("t4_head",  64'(deq_addr),       64'h55);
    check("t4_hit",   64'(lookup_hit),     64'h1);
    check("t4_vec",   64'(lookup_hit_vec), 64'b0000_0010);

    // 5: flush beats simultaneous enq and deq
    enq(32'h66); enq(32'h67);
    step(1'b1, 32'h77, 1'b1, 1'b1);
    probe(32'h77);
    check("t5_count", 64'(count),      64'd0);
    check("t5_empty", 64'(empty),      64'h1);
    check("t5_hit77", 64'(lookup_hit), 64'h0);
    probe(32'h55);
    check("t5_hit55", 64'(lookup_hit), 64'h0);

    // duplicates may hit in several slots
    enq(32'h5); enq(32'h6); enq(32'h5);
    probe(32'h5);
    check("dup_vec", 64'(lookup_hit_vec), 64'b0000_0101);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("dup_vec2", 64'(lookup_hit_vec), 64'b0000_0100);

    // 6: asynchronous reset between edges
    do_reset();
    enq(32'hA0); enq(32'hB0);
    probe(32'hA0);
    check("t6_pre_hit", 64'(lookup_hit), 64'h1);
    reset = 1'b1;
    #1;
    check("t6_empty", 64'(empty),      64'h1);
    check("t6_hit",   64'(lookup_hit), 64'h0);
    check("t6_addr",  64'(deq_addr),   64'h0);
    check("t6_count", 64'(count),      64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // mixed traffic against the model
    for (int i = 0; i < 60; i++) begin
      lookup_addr = 32'($urandom_range(1, 6));
      step(1'($urandom_range(0, 1)), 32'($urandom_range(1, 6)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end
    repeat (2) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
